// File: rtl/idma_pkg.sv
// Shared types and widths for the iDMA write-channel scheduler.
package idma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_INIT,
    S_PUSH,
    S_WAIT,
    S_DONE
  } wr_sched_st_e;

  localparam int IDMA_ADDR_W   = 32;
  localparam int IDMA_LEN_W    = 32;
  localparam int IDMA_OUTSTD_W = 4;

endpackage

// File: rtl/idma_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping modulo N.
module idma_rr_arb #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  logic [W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = W'((int'(ptr_i) + i) % N);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/idma_wr_chn_sched.sv
// Round-robin scheduler sharing one AXI write engine among NUM_CH iDMA write channels.
module idma_wr_chn_sched
  import idma_pkg::*;
#(
  parameter int          NUM_CH  = 4,
  parameter logic [15:0] DONE_TO = 16'hFFFF,
  localparam int         CHW     = $clog2(NUM_CH)
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [NUM_CH-1:0]                   ch_req,
  input  logic [NUM_CH*IDMA_ADDR_W-1:0]       ch_addr,
  input  logic [NUM_CH*IDMA_LEN_W-1:0]        ch_num_word,
  input  logic [NUM_CH*IDMA_OUTSTD_W-1:0]     ch_outstd,
  input  logic [NUM_CH-1:0]                   ch_outstd_en,
  input  logic [NUM_CH-1:0]                   ch_cross4k_en,
  output logic [NUM_CH-1:0]                   ch_gnt,
  output logic [NUM_CH-1:0]                   ch_done,
  output logic                                ch_err,
  output logic                                wr_cfg_init,
  output logic                                wr_cfg_ready,
  output logic [IDMA_OUTSTD_W-1:0]            wr_cfg_outstd,
  output logic                                wr_cfg_outstd_en,
  output logic                                wr_cfg_cross4k_en,
  output logic                                cmd_push,
  output logic [IDMA_ADDR_W-1:0]              cmd_addr,
  output logic [IDMA_LEN_W-1:0]               cmd_num_word,
  input  logic                                cmd_full,
  input  logic                                write_all_done,
  output logic                                busy,
  output logic [CHW-1:0]                      cur_ch
);

  wr_sched_st_e              state_q, state_d;
  logic [CHW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [CHW-1:0]            cur_ch_q, cur_ch_d;
  logic [IDMA_ADDR_W-1:0]    addr_q, addr_d;
  logic [IDMA_LEN_W-1:0]     num_word_q, num_word_d;
  logic [IDMA_OUTSTD_W-1:0]  outstd_q, outstd_d;
  logic                      outstd_en_q, outstd_en_d;
  logic                      cross4k_q, cross4k_d;
  logic                      err_q, err_d;
  logic [15:0]               to_cnt_q, to_cnt_d;

  logic [NUM_CH-1:0]         arb_gnt;
  logic [CHW-1:0]            arb_idx;
  logic                      arb_any;

  logic [IDMA_ADDR_W-1:0]    addr_a     [NUM_CH];
  logic [IDMA_LEN_W-1:0]     num_word_a [NUM_CH];
  logic [IDMA_OUTSTD_W-1:0]  outstd_a   [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign addr_a[g]     = ch_addr[g*IDMA_ADDR_W +: IDMA_ADDR_W];
    assign num_word_a[g] = ch_num_word[g*IDMA_LEN_W +: IDMA_LEN_W];
    assign outstd_a[g]   = ch_outstd[g*IDMA_OUTSTD_W +: IDMA_OUTSTD_W];
  end

  idma_rr_arb #(
    .N (NUM_CH),
    .W (CHW)
  ) u_arb (
    .req_i (ch_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cur_ch_d    = cur_ch_q;
    addr_d      = addr_q;
    num_word_d  = num_word_q;
    outstd_d    = outstd_q;
    outstd_en_d = outstd_en_q;
    cross4k_d   = cross4k_q;
    err_d       = err_q;
    to_cnt_d    = to_cnt_q;
    ch_gnt      = '0;
    ch_done     = '0;
    ch_err      = 1'b0;
    wr_cfg_init = 1'b0;
    cmd_push    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (|ch_req) state_d = S_GRANT;
      end
      // A request withdrawn before this cycle simply falls back to IDLE.
      S_GRANT: begin
        if (arb_any) begin
          ch_gnt      = arb_gnt;
          cur_ch_d    = arb_idx;
          addr_d      = addr_a[arb_idx];
          num_word_d  = num_word_a[arb_idx];
          outstd_d    = outstd_a[arb_idx];
          outstd_en_d = ch_outstd_en[arb_idx];
          cross4k_d   = ch_cross4k_en[arb_idx];
          rr_ptr_d    = (arb_idx == CHW'(NUM_CH - 1)) ? '0 : arb_idx + 1'b1;
          if (num_word_a[arb_idx] == '0) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INIT: begin
        wr_cfg_init = 1'b1;
        state_d     = S_PUSH;
      end
      S_PUSH: begin
        if (!cmd_full) begin
          cmd_push = 1'b1;
          to_cnt_d = '0;
          state_d  = S_WAIT;
        end
      end
      // Completion is only looked at from the cycle after the push onward.
      S_WAIT: begin
        if (write_all_done) begin
          state_d = S_DONE;
        end else if ((DONE_TO != 16'd0) && (to_cnt_q == DONE_TO - 16'd1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (to_cnt_q != 16'hFFFF) begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        ch_done[cur_ch_q] = 1'b1;
        ch_err            = err_q;
        state_d           = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      cur_ch_q    <= '0;
      addr_q      <= '0;
      num_word_q  <= '0;
      outstd_q    <= '0;
      outstd_en_q <= 1'b0;
      cross4k_q   <= 1'b0;
      err_q       <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_ch_q    <= cur_ch_d;
      addr_q      <= addr_d;
      num_word_q  <= num_word_d;
      outstd_q    <= outstd_d;
      outstd_en_q <= outstd_en_d;
      cross4k_q   <= cross4k_d;
      err_q       <= err_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign wr_cfg_ready      = (state_q == S_INIT) || (state_q == S_PUSH) || (state_q == S_WAIT);
  assign wr_cfg_outstd     = outstd_q;
  assign wr_cfg_outstd_en  = outstd_en_q;
  assign wr_cfg_cross4k_en = cross4k_q;
  assign cmd_addr          = addr_q;
  assign cmd_num_word      = num_word_q;
  assign busy              = (state_q != S_IDLE);
  assign cur_ch            = cur_ch_q;

endmodule

// File: tb/tb_idma_wr_chn_sched.sv
// Directed bench for idma_wr_chn_sched: vector table for normal/zero-length transfers, hand sequences for the rest.
module tb_idma_wr_chn_sched;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [3:0]   ch_req = '0;
  logic [127:0] ch_addr;
  logic [127:0] ch_num_word;
  logic [15:0]  ch_outstd;
  logic [3:0]   ch_outstd_en;
  logic [3:0]   ch_cross4k_en;
  logic [3:0]   ch_gnt;
  logic [3:0]   ch_done;
  logic         ch_err;
  logic         wr_cfg_init;
  logic         wr_cfg_ready;
  logic [3:0]   wr_cfg_outstd;
  logic         wr_cfg_outstd_en;
  logic         wr_cfg_cross4k_en;
  logic         cmd_push;
  logic [31:0]  cmd_addr;
  logic [31:0]  cmd_num_word;
  logic         cmd_full = 1'b0;
  logic         write_all_done = 1'b0;
  logic         busy;
  logic [1:0]   cur_ch;

  logic [31:0]  nw3 = 32'd128;

  int checkCount = 0;
  int passCount  = 0;

  // Fixed per-channel programming: addr i*0x1000, num_word 32*(i+1), outstd i+5.
  assign ch_addr       = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
  assign ch_num_word   = {nw3, 32'd96, 32'd64, 32'd32};
  assign ch_outstd     = {4'd8, 4'd7, 4'd6, 4'd5};
  assign ch_outstd_en  = 4'b0101;
  assign ch_cross4k_en = 4'b0011;

  always #5 aclk = ~aclk;

  idma_wr_chn_sched #(
    .NUM_CH  (4),
    .DONE_TO (16'd100)
  ) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .ch_req            (ch_req),
    .ch_addr           (ch_addr),
    .ch_num_word       (ch_num_word),
    .ch_outstd         (ch_outstd),
    .ch_outstd_en      (ch_outstd_en),
    .ch_cross4k_en     (ch_cross4k_en),
    .ch_gnt            (ch_gnt),
    .ch_done           (ch_done),
    .ch_err            (ch_err),
    .wr_cfg_init       (wr_cfg_init),
    .wr_cfg_ready      (wr_cfg_ready),
    .wr_cfg_outstd     (wr_cfg_outstd),
    .wr_cfg_outstd_en  (wr_cfg_outstd_en),
    .wr_cfg_cross4k_en (wr_cfg_cross4k_en),
    .cmd_push          (cmd_push),
    .cmd_addr          (cmd_addr),
    .cmd_num_word      (cmd_num_word),
    .cmd_full          (cmd_full),
    .write_all_done    (write_all_done),
    .busy              (busy),
    .cur_ch            (cur_ch)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] nw3;
    logic [3:0]  expGnt;
    logic [1:0]  expCh;
    logic [31:0] expAddr;
    logic [31:0] expNw;
    logic [3:0]  expOutstd;
    logic        expOutEn;
    logic        expX4k;
    logic        expErr;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic nextCycle();
    @(posedge aclk);
    #1;
  endtask

  // Wait (bounded) for a grant; the caller then compares ch_gnt to what it expects.
  task automatic waitGrant();
    int waitCnt;
    waitCnt = 0;
    @(negedge aclk);
    while (ch_gnt == 4'b0000 && waitCnt < 10) begin
      nextCycle();
      @(negedge aclk);
      waitCnt++;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    nw3    = v.nw3;
    ch_req = v.req;
    waitGrant();
    checkOutput("gnt", 32'(ch_gnt), 32'(v.expGnt));
    nextCycle();
    ch_req = ch_req & ~v.expGnt;
    if (!v.expErr) begin
      @(negedge aclk);
      checkOutput("init", 32'(wr_cfg_init), 32'd1);
      checkOutput("cfg_ready", 32'(wr_cfg_ready), 32'd1);
      checkOutput("cur_ch", 32'(cur_ch), 32'(v.expCh));
      checkOutput("outstd", 32'(wr_cfg_outstd), 32'(v.expOutstd));
      checkOutput("outstd_en", 32'(wr_cfg_outstd_en), 32'(v.expOutEn));
      checkOutput("cross4k", 32'(wr_cfg_cross4k_en), 32'(v.expX4k));
      nextCycle();
      @(negedge aclk);
      checkOutput("push", 32'(cmd_push), 32'd1);
      checkOutput("cmd_addr", cmd_addr, v.expAddr);
      checkOutput("cmd_nw", cmd_num_word, v.expNw);
      nextCycle();
      write_all_done = 1'b1;
      nextCycle();
      write_all_done = 1'b0;
      @(negedge aclk);
      checkOutput("done", 32'(ch_done), 32'(v.expGnt));
      checkOutput("err", 32'(ch_err), 32'd0);
      checkOutput("ready_drop", 32'(wr_cfg_ready), 32'd0);
    end else begin
      @(negedge aclk);
      checkOutput("zl_done", 32'(ch_done), 32'(v.expGnt));
      checkOutput("zl_err", 32'(ch_err), 32'd1);
      checkOutput("zl_push", 32'(cmd_push), 32'd0);
      checkOutput("zl_init", 32'(wr_cfg_init), 32'd0);
    end
    nextCycle();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pushSeen;
    int stallBad;
    int cyc;

    vecs[0] = '{4'b1111, 32'd128, 4'b0001, 2'd0, 32'h0000, 32'd32,  4'd5, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{4'b1111, 32'd128, 4'b0010, 2'd1, 32'h1000, 32'd64,  4'd6, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{4'b1111, 32'd128, 4'b0100, 2'd2, 32'h2000, 32'd96,  4'd7, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{4'b1111, 32'd128, 4'b1000, 2'd3, 32'h3000, 32'd128, 4'd8, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{4'b1111, 32'd128, 4'b0001, 2'd0, 32'h0000, 32'd32,  4'd5, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{4'b1111, 32'd128, 4'b0010, 2'd1, 32'h1000, 32'd64,  4'd6, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{4'b1111, 32'd128, 4'b0100, 2'd2, 32'h2000, 32'd96,  4'd7, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{4'b1111, 32'd128, 4'b1000, 2'd3, 32'h3000, 32'd128, 4'd8, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{4'b0010, 32'd128, 4'b0010, 2'd1, 32'h1000, 32'd64,  4'd6, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{4'b1000, 32'd0,   4'b1000, 2'd3, 32'h0000, 32'd0,   4'd0, 1'b0, 1'b0, 1'b1};

    @(negedge aclk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_gnt", 32'(ch_gnt), 32'd0);
    checkOutput("rst_done", 32'(ch_done), 32'd0);
    checkOutput("rst_ready", 32'(wr_cfg_ready), 32'd0);
    checkOutput("rst_push", 32'(cmd_push), 32'd0);
    checkOutput("rst_addr", cmd_addr, 32'd0);
    repeat (2) nextCycle();
    aresetn = 1'b1;
    nextCycle();

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    // Backpressure on ch0: FIFO full for 20 PUSH cycles, then exactly one push.
    cmd_full = 1'b1;
    ch_req   = 4'b0001;
    waitGrant();
    checkOutput("bp_gnt", 32'(ch_gnt), 32'b0001);
    nextCycle();
    ch_req = 4'b0000;
    nextCycle();
    pushSeen = 0;
    stallBad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (cmd_push) pushSeen++;
      if (!busy || !wr_cfg_ready || wr_cfg_init || ch_done != 4'b0000) stallBad++;
      nextCycle();
    end
    checkOutput("bp_nopush", 32'(pushSeen), 32'd0);
    checkOutput("bp_stall", 32'(stallBad), 32'd0);
    cmd_full = 1'b0;
    @(negedge aclk);
    checkOutput("bp_push", 32'(cmd_push), 32'd1);
    checkOutput("bp_addr", cmd_addr, 32'h0000);
    nextCycle();
    @(negedge aclk);
    checkOutput("bp_single", 32'(cmd_push), 32'd0);
    write_all_done = 1'b1;
    nextCycle();
    write_all_done = 1'b0;
    @(negedge aclk);
    checkOutput("bp_done", 32'(ch_done), 32'b0001);
    checkOutput("bp_err", 32'(ch_err), 32'd0);
    nextCycle();

    // Timeout on ch1: completion never arrives, DONE after 100 WAIT cycles.
    ch_req = 4'b0010;
    waitGrant();
    checkOutput("to_gnt", 32'(ch_gnt), 32'b0010);
    nextCycle();
    ch_req = 4'b0000;
    nextCycle();
    @(negedge aclk);
    checkOutput("to_push", 32'(cmd_push), 32'd1);
    cyc = 0;
    nextCycle();
    @(negedge aclk);
    while (ch_done == 4'b0000 && cyc < 200) begin
      cyc++;
      nextCycle();
      @(negedge aclk);
    end
    checkOutput("to_cycles", 32'(cyc), 32'd100);
    checkOutput("to_done", 32'(ch_done), 32'b0010);
    checkOutput("to_err", 32'(ch_err), 32'd1);
    nextCycle();

    // Reset while ch2 sits in WAIT: silent abort, pointer back to 0.
    ch_req = 4'b0100;
    waitGrant();
    checkOutput("rs_gnt", 32'(ch_gnt), 32'b0100);
    nextCycle();
    ch_req = 4'b0000;
    repeat (3) nextCycle();
    aresetn = 1'b0;
    @(negedge aclk);
    checkOutput("rs_busy", 32'(busy), 32'd0);
    checkOutput("rs_done", 32'(ch_done), 32'd0);
    checkOutput("rs_ready", 32'(wr_cfg_ready), 32'd0);
    checkOutput("rs_addr", cmd_addr, 32'd0);
    checkOutput("rs_nw", cmd_num_word, 32'd0);
    checkOutput("rs_cur_ch", 32'(cur_ch), 32'd0);
    checkOutput("rs_outstd", 32'(wr_cfg_outstd), 32'd0);
    repeat (2) nextCycle();
    nextCycle();
    aresetn = 1'b1;
    stallBad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      if (busy || ch_done != 4'b0000) stallBad++;
      nextCycle();
    end
    checkOutput("rs_quiet", 32'(stallBad), 32'd0);
    applyStimulus(vecs[0]);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
